// File: rtl/pipeline_stall_ctrl.sv
// Central stall controller: per-stage stall masks, MDU cycle counter and data-bus handshake FSM.
// Stall vector is combinational; counter/FSM outputs are registered. Flush aborts all sequencing.
module pipeline_stall_ctrl #(
  parameter int MUL_CYCLES  = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       if_stall_req,
  input  logic       id_load_use_req,
  input  logic       ex_mdu_start,
  input  logic       ex_mdu_is_div,
  input  logic       mem_req,
  input  logic       dbus_ack,
  output logic       dbus_req,
  output logic       bus_error,
  output logic       mdu_busy,
  output logic       mdu_done,
  output logic [4:0] stall
);

  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_BUSY = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_t;

  mem_state_t      state_q;
  logic [TW-1:0]   tmo_q;
  logic            dbus_req_q;
  logic            bus_error_q;

  logic [5:0]      cnt_q, cnt_d;
  logic            mdu_done_q, mdu_done_d;

  logic            mdu_busy_w;
  logic            ex_req;
  logic            mem_stall_req;

  assign mdu_busy_w = (cnt_q != 6'd0);

  // MDU counter: loads N-1 on an accepted start, then counts down to idle.
  always_comb begin
    cnt_d      = cnt_q;
    mdu_done_d = 1'b0;
    if (flush) begin
      cnt_d = 6'd0;
    end else if (mdu_busy_w) begin
      cnt_d      = cnt_q - 6'd1;
      mdu_done_d = (cnt_q == 6'd1);
    end else if (ex_mdu_start) begin
      cnt_d = ex_mdu_is_div ? 6'(DIV_CYCLES - 1) : 6'(MUL_CYCLES - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q      <= 6'd0;
      mdu_done_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      mdu_done_q <= mdu_done_d;
    end
  end

  // Data-bus handshake; an ack in the final timeout cycle still counts as success.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      state_q     <= MEM_IDLE;
      tmo_q       <= '0;
      dbus_req_q  <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      bus_error_q <= 1'b0;
      case (state_q)
        MEM_IDLE: begin
          if (mem_req) begin
            state_q    <= MEM_BUSY;
            tmo_q      <= '0;
            dbus_req_q <= 1'b1;
          end
        end
        MEM_BUSY: begin
          if (dbus_ack) begin
            state_q    <= MEM_DONE;
            dbus_req_q <= 1'b0;
          end else if (tmo_q == TW'(MEM_TIMEOUT - 1)) begin
            state_q     <= MEM_DONE;
            dbus_req_q  <= 1'b0;
            bus_error_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        MEM_DONE: begin
          state_q <= MEM_IDLE;
        end
        default: begin
          state_q    <= MEM_IDLE;
          dbus_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign ex_req        = (ex_mdu_start & ~mdu_busy_w) | mdu_busy_w;
  assign mem_stall_req = ((state_q == MEM_IDLE) & mem_req) | (state_q == MEM_BUSY);

  always_comb begin
    stall = 5'b00000;
    if (!flush) begin
      if (if_stall_req)    stall = stall | 5'b00011;
      if (id_load_use_req) stall = stall | 5'b00111;
      if (ex_req)          stall = stall | 5'b01111;
      if (mem_stall_req)   stall = stall | 5'b11111;
    end
  end

  assign dbus_req  = dbus_req_q;
  assign bus_error = bus_error_q;
  assign mdu_busy  = mdu_busy_w;
  assign mdu_done  = mdu_done_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl (MUL 4, DIV 8, MEM_TIMEOUT 5).
module tb_pipeline_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst, flush, if_stall_req, id_load_use_req;
  logic       ex_mdu_start, ex_mdu_is_div, mem_req, dbus_ack;
  logic       dbus_req, bus_error, mdu_busy, mdu_done;
  logic [4:0] stall;

  int passed = 0;
  int total  = 0;

  pipeline_stall_ctrl #(
    .MUL_CYCLES (4),
    .DIV_CYCLES (8),
    .MEM_TIMEOUT(5)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .if_stall_req   (if_stall_req),
    .id_load_use_req(id_load_use_req),
    .ex_mdu_start   (ex_mdu_start),
    .ex_mdu_is_div  (ex_mdu_is_div),
    .mem_req        (mem_req),
    .dbus_ack       (dbus_ack),
    .dbus_req       (dbus_req),
    .bus_error      (bus_error),
    .mdu_busy       (mdu_busy),
    .mdu_done       (mdu_done),
    .stall          (stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge; checks follow after a short settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; if_stall_req = 1'b0; id_load_use_req = 1'b0;
    ex_mdu_start = 1'b0; ex_mdu_is_div = 1'b0; mem_req = 1'b0; dbus_ack = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #2;
    chk("rst_stall", 8'(stall), 8'h00);
    chk("rst_dbus_req", 8'(dbus_req), 8'h0);
    chk("rst_mdu_busy", 8'(mdu_busy), 8'h0);
    chk("rst_mdu_done", 8'(mdu_done), 8'h0);
    chk("rst_bus_error", 8'(bus_error), 8'h0);

    // Stall masks
    tick(); if_stall_req = 1'b1; #2;
    chk("if_mask", 8'(stall), 8'h03);
    tick(); if_stall_req = 1'b0; id_load_use_req = 1'b1; #2;
    chk("id_mask", 8'(stall), 8'h07);
    if_stall_req = 1'b1; #1;
    chk("id_if_mask", 8'(stall), 8'h07);
    tick(); if_stall_req = 1'b0; id_load_use_req = 1'b0; #2;
    chk("mask_clear", 8'(stall), 8'h00);

    // Multiply: start t, busy t+1..t+3, done t+4; restart at t+2 ignored
    tick(); ex_mdu_start = 1'b1; ex_mdu_is_div = 1'b0; #2;
    chk("mul_t0_stall", 8'(stall), 8'h0F);
    chk("mul_t0_busy", 8'(mdu_busy), 8'h0);
    tick(); ex_mdu_start = 1'b0; #2;
    chk("mul_t1_stall", 8'(stall), 8'h0F);
    chk("mul_t1_busy", 8'(mdu_busy), 8'h1);
    tick(); ex_mdu_start = 1'b1; #2;
    chk("mul_t2_stall", 8'(stall), 8'h0F);
    tick(); ex_mdu_start = 1'b0; #2;
    chk("mul_t3_stall", 8'(stall), 8'h0F);
    chk("mul_t3_done", 8'(mdu_done), 8'h0);
    tick(); #2;
    chk("mul_t4_stall", 8'(stall), 8'h00);
    chk("mul_t4_busy", 8'(mdu_busy), 8'h0);
    chk("mul_t4_done", 8'(mdu_done), 8'h1);
    tick(); #2;
    chk("mul_t5_done", 8'(mdu_done), 8'h0);

    // Load: request t, ack t+3, DONE t+4 (mem_req held but ignored), IDLE t+5
    tick(); mem_req = 1'b1; #2;
    chk("ld_t0_stall", 8'(stall), 8'h1F);
    chk("ld_t0_dbus_req", 8'(dbus_req), 8'h0);
    tick(); #2;
    chk("ld_t1_dbus_req", 8'(dbus_req), 8'h1);
    chk("ld_t1_stall", 8'(stall), 8'h1F);
    tick(); #2;
    chk("ld_t2_dbus_req", 8'(dbus_req), 8'h1);
    tick(); dbus_ack = 1'b1; #2;
    chk("ld_t3_dbus_req", 8'(dbus_req), 8'h1);
    chk("ld_t3_stall", 8'(stall), 8'h1F);
    tick(); dbus_ack = 1'b0; #2;
    chk("ld_done_stall", 8'(stall), 8'h00);
    chk("ld_done_dbus_req", 8'(dbus_req), 8'h0);
    chk("ld_done_bus_error", 8'(bus_error), 8'h0);
    tick(); mem_req = 1'b0; dbus_ack = 1'b1; #2;
    chk("ld_idle_stall", 8'(stall), 8'h00);
    tick(); dbus_ack = 1'b0; #2;
    chk("ack_in_idle_ignored", 8'(dbus_req), 8'h0);

    // Timeout: BUSY exactly 5 cycles, then DONE with bus_error, then IDLE
    tick(); mem_req = 1'b1; #2;
    chk("to_t0_stall", 8'(stall), 8'h1F);
    for (int i = 1; i <= 5; i++) begin
      tick(); #2;
      chk($sformatf("to_busy%0d_dbus_req", i), 8'(dbus_req), 8'h1);
      chk($sformatf("to_busy%0d_bus_error", i), 8'(bus_error), 8'h0);
    end
    tick(); #2;
    chk("to_done_bus_error", 8'(bus_error), 8'h1);
    chk("to_done_dbus_req", 8'(dbus_req), 8'h0);
    chk("to_done_stall", 8'(stall), 8'h00);
    tick(); mem_req = 1'b0; #2;
    chk("to_idle_bus_error", 8'(bus_error), 8'h0);
    chk("to_idle_dbus_req", 8'(dbus_req), 8'h0);

    // Divide plus memory BUSY, then flush
    tick(); ex_mdu_start = 1'b1; ex_mdu_is_div = 1'b1; mem_req = 1'b1; #2;
    chk("fl_t0_stall", 8'(stall), 8'h1F);
    tick(); ex_mdu_start = 1'b0; mem_req = 1'b0; #2;
    chk("fl_t1_stall", 8'(stall), 8'h1F);
    chk("fl_t1_busy", 8'(mdu_busy), 8'h1);
    chk("fl_t1_dbus_req", 8'(dbus_req), 8'h1);
    tick(); flush = 1'b1; #2;
    chk("fl_stall", 8'(stall), 8'h00);
    tick(); flush = 1'b0; #2;
    chk("fl_after_dbus_req", 8'(dbus_req), 8'h0);
    chk("fl_after_busy", 8'(mdu_busy), 8'h0);
    chk("fl_after_stall", 8'(stall), 8'h00);
    for (int i = 0; i < 8; i++) begin
      tick(); #2;
      chk($sformatf("fl_no_done%0d", i), 8'(mdu_done), 8'h0);
    end

    // Flush overrides same-cycle start and request
    flush = 1'b1; ex_mdu_start = 1'b1; mem_req = 1'b1; #1;
    chk("fl_ovr_stall", 8'(stall), 8'h00);
    tick(); flush = 1'b0; ex_mdu_start = 1'b0; mem_req = 1'b0; #2;
    chk("fl_ovr_busy", 8'(mdu_busy), 8'h0);
    chk("fl_ovr_dbus_req", 8'(dbus_req), 8'h0);

    // Reset mid-operation
    tick(); ex_mdu_start = 1'b1; ex_mdu_is_div = 1'b1; mem_req = 1'b1;
    tick(); ex_mdu_start = 1'b0; mem_req = 1'b0; rst = 1'b0;
    tick(); rst = 1'b1; #2;
    chk("mid_rst_busy", 8'(mdu_busy), 8'h0);
    chk("mid_rst_dbus_req", 8'(dbus_req), 8'h0);
    chk("mid_rst_stall", 8'(stall), 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
